// File: rtl/fft_sequencer_if.sv
// Signal bundle between the FFT run controller, its host and the stage controller.
// The controller takes the slave side; the host/stage-controller side takes master.
interface fft_sequencer_if #(
    parameter int unsigned NUMSTAGES = 5
);
    logic                 start;
    logic                 abort;
    logic                 stage_done;
    logic                 ld_data;
    logic [NUMSTAGES-3:0] ld_addr;
    logic                 stage_en;
    logic [2:0]           stage_num;
    logic                 out_valid;
    logic [NUMSTAGES-3:0] out_addr;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, abort, stage_done,
        input  ld_data, ld_addr, stage_en, stage_num, out_valid, out_addr, busy, done, err
    );

    modport slave (
        input  start, abort, stage_done,
        output ld_data, ld_addr, stage_en, stage_num, out_valid, out_addr, busy, done, err
    );
endinterface

// File: rtl/fft_sequencer.sv
// Run controller for the radix-2 FFT core: load phase, NUMSTAGES butterfly stages
// separated by one-cycle gaps, unload phase, with stage watchdog and host abort.
module fft_sequencer #(
    parameter int unsigned NUMSTAGES     = 5,
    parameter int unsigned XFER_CYCLES   = 8,
    parameter int unsigned STAGE_TIMEOUT = 16
) (
    input logic            clk,
    input logic            rst_n,
    fft_sequencer_if.slave bus
);
    localparam int unsigned AW = NUMSTAGES - 2;
    localparam int unsigned WW = $clog2(STAGE_TIMEOUT);
    localparam logic [AW-1:0] LastAddr  = AW'(XFER_CYCLES - 1);
    localparam logic [WW-1:0] WdogLast  = WW'(STAGE_TIMEOUT - 1);
    localparam logic [2:0]    LastStage = 3'(NUMSTAGES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStage,
        StGap,
        StUnload,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [2:0]    stage_num_q, stage_num_d;
    logic          err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        wdog_d      = '0;
        stage_num_d = stage_num_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    state_d = StLoad;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (cnt_q == LastAddr) begin
                    state_d = StStage;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStage: begin
                // stage_done wins over a watchdog expiry in the same cycle
                if (bus.stage_done) begin
                    state_d = StGap;
                end else if (wdog_q == WdogLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StGap: begin
                if (stage_num_q == LastStage) begin
                    state_d = StUnload;
                end else begin
                    state_d     = StStage;
                    stage_num_d = stage_num_q + 3'd1;
                end
            end
            StUnload: begin
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle && bus.abort) begin
            state_d = StIdle;
            err_d   = err_q;
        end

        if (state_d == StIdle) begin
            stage_num_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wdog_q      <= '0;
            stage_num_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            stage_num_q <= stage_num_d;
            err_q       <= err_d;
        end
    end

    assign bus.ld_data   = (state_q == StLoad);
    assign bus.ld_addr   = (state_q == StLoad) ? cnt_q : '0;
    assign bus.stage_en  = (state_q == StStage);
    assign bus.stage_num = stage_num_q;
    assign bus.out_valid = (state_q == StUnload);
    assign bus.out_addr  = (state_q == StUnload) ? cnt_q : '0;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);
    assign bus.err       = err_q;
endmodule
